// File: rtl/mem_bank_2r1w.sv
// Two-read / one-write table memory with a sequential clear sweep.
// Read ports are combinational (READ_LAT=0) or registered with write-through (READ_LAT=1).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | normal operation; writes accepted, reads return memory contents
// CLEAR | sweep writes INIT_VAL to mem[clr_ptr] each cycle; busy asserted
module mem_bank_2r1w #(
   parameter int                 DATA_W   = 13,
   parameter int                 ADDR_W   = 6,
   parameter int                 DEPTH    = 64,
   parameter int                 READ_LAT = 0,
   parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   output logic              busy,
   input  logic              w_rb,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] data_in,
   output logic              wr_drop,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_out,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_out
);

   typedef enum logic {IDLE, CLEAR} state_t;

   // one extra bit so DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH-1);

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic w_in_range;
   logic ra_in_range;
   logic rb_in_range;
   logic clear_start;
   logic wr_ok;
   logic wr_bad;

   assign w_in_range  = {1'b0, w_addr}  < DEPTH_EXT;
   assign ra_in_range = {1'b0, ra_addr} < DEPTH_EXT;
   assign rb_in_range = {1'b0, rb_addr} < DEPTH_EXT;

   assign busy        = (state == CLEAR);
   assign clear_start = !reset && (state == IDLE) && clr;
   // a clear request in the same cycle takes precedence over the write
   assign wr_ok       = !reset && (state == IDLE) && !clr && w_rb && w_in_range;
   assign wr_bad      = w_rb && (busy || !w_in_range || ((state == IDLE) && clr));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= wr_bad;
         case (state)
            IDLE: begin
               if (clr) begin
                  state   <= CLEAR;
                  clr_ptr <= '0;
               end
            end
            CLEAR: begin
               if (clr_ptr == LAST_PTR) begin
                  state   <= IDLE;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + 1'b1;
               end
            end
            default: begin
               state   <= CLEAR;
               clr_ptr <= '0;
            end
         endcase
      end
   end

   // contents are only ever cleared by the sweep, never by reset directly
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_ptr] <= INIT_VAL;
         end else if (wr_ok) begin
            mem[w_addr] <= data_in;
         end
      end
   end

   generate
      if (DEPTH < 1 || DEPTH > (2**ADDR_W)) begin : g_bad_depth
         $error("mem_bank_2r1w: DEPTH must be in 1..2**ADDR_W");
      end

      if (READ_LAT == 0) begin : g_rd_comb
         assign ra_out = (busy || !ra_in_range) ? INIT_VAL : mem[ra_addr];
         assign rb_out = (busy || !rb_in_range) ? INIT_VAL : mem[rb_addr];
      end else if (READ_LAT == 1) begin : g_rd_reg
         always_ff @(posedge clk) begin
            if (reset) begin
               ra_out <= INIT_VAL;
               rb_out <= INIT_VAL;
            end else begin
               if (busy || !ra_in_range || clear_start)
                  ra_out <= INIT_VAL;
               else if (wr_ok && (w_addr == ra_addr))
                  ra_out <= data_in;
               else
                  ra_out <= mem[ra_addr];

               if (busy || !rb_in_range || clear_start)
                  rb_out <= INIT_VAL;
               else if (wr_ok && (w_addr == rb_addr))
                  rb_out <= data_in;
               else
                  rb_out <= mem[rb_addr];
            end
         end
      end else begin : g_bad_lat
         $error("mem_bank_2r1w: READ_LAT must be 0 or 1");
      end
   endgenerate

endmodule

// File: tb/tb_mem_bank_2r1w.sv
// Directed bench for mem_bank_2r1w; three instances share stimulus:
// u0 = 64/lat0/INIT 0, u1 = 48/lat1/INIT 0, u2 = 64/lat0/INIT 1FFF.
module tb_mem_bank_2r1w;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        w_rb;
   logic [5:0]  w_addr;
   logic [12:0] data_in;
   logic [5:0]  ra_addr;
   logic [5:0]  rb_addr;

   logic        busy0, busy1, busy2;
   logic        wr_drop0, wr_drop1, wr_drop2;
   logic [12:0] ra0, ra1, ra2;
   logic [12:0] rb0, rb1, rb2;

   int n_tot = 0;
   int n_bad = 0;
   int n;
   int seen_bad;

   mem_bank_2r1w #(.DATA_W(13), .ADDR_W(6), .DEPTH(64), .READ_LAT(0), .INIT_VAL(13'h0000)) u0 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy0), .w_rb(w_rb), .w_addr(w_addr),
      .data_in(data_in), .wr_drop(wr_drop0), .ra_addr(ra_addr), .ra_out(ra0),
      .rb_addr(rb_addr), .rb_out(rb0));

   mem_bank_2r1w #(.DATA_W(13), .ADDR_W(6), .DEPTH(48), .READ_LAT(1), .INIT_VAL(13'h0000)) u1 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy1), .w_rb(w_rb), .w_addr(w_addr),
      .data_in(data_in), .wr_drop(wr_drop1), .ra_addr(ra_addr), .ra_out(ra1),
      .rb_addr(rb_addr), .rb_out(rb1));

   mem_bank_2r1w #(.DATA_W(13), .ADDR_W(6), .DEPTH(64), .READ_LAT(0), .INIT_VAL(13'h1FFF)) u2 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy2), .w_rb(w_rb), .w_addr(w_addr),
      .data_in(data_in), .wr_drop(wr_drop2), .ra_addr(ra_addr), .ra_out(ra2),
      .rb_addr(rb_addr), .rb_out(rb2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy0 || busy1 || busy2) && k < 300) begin
         tick();
         k++;
      end
      chk("idle_timeout", 32'(k < 300), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clr = 1'b0; w_rb = 1'b0; w_addr = '0; data_in = '0;
      ra_addr = '0; rb_addr = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", 32'(busy0), 32'd1);
      chk("rst_wr_drop", 32'(wr_drop0), 32'd0);
      chk("rst_ra_reg", 32'(ra1), 32'd0);
      chk("rst_ra_busy", 32'(ra2), 32'h1FFF);
      wait_idle();

      // reset sweep clears a written entry; busy lasts exactly DEPTH cycles
      w_rb = 1'b1; w_addr = 6'd5; data_in = 13'h1ABC; ra_addr = 6'd5;
      tick();
      w_rb = 1'b0;
      chk("t1_write", 32'(ra0), 32'h1ABC);
      chk("t1_no_drop", 32'(wr_drop0), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0; seen_bad = 0;
      while (busy0 && n < 200) begin
         if (ra0 !== 13'h0000) seen_bad = 1;
         tick();
         n++;
      end
      chk("t1_busy_len", 32'(n), 32'd64);
      chk("t1_ra_during", 32'(seen_bad), 32'd0);
      chk("t1_ra_after", 32'(ra0), 32'h0000);
      wait_idle();

      // lat0 write then dual read; no same-cycle bypass
      w_rb = 1'b1; w_addr = 6'd10; data_in = 13'h0F0F; ra_addr = 6'd10; rb_addr = 6'd10;
      #1;
      chk("t2_no_bypass", 32'(ra0), 32'h0000);
      tick();
      w_rb = 1'b0;
      chk("t2_ra", 32'(ra0), 32'h0F0F);
      chk("t2_rb", 32'(rb0), 32'h0F0F);

      // lat1 write-through bypass
      w_rb = 1'b1; w_addr = 6'd3; data_in = 13'h1234; ra_addr = 6'd3; rb_addr = 6'd4;
      #1;
      chk("t3_ra_held", 32'(ra1), 32'h0F0F);
      tick();
      w_rb = 1'b0;
      chk("t3_ra_bypass", 32'(ra1), 32'h1234);
      chk("t3_rb", 32'(rb1), 32'h0000);
      tick();
      chk("t3_ra_mem", 32'(ra1), 32'h1234);

      // write during sweep is dropped
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_busy", 32'(busy0), 32'd1);
      repeat (9) tick();
      w_rb = 1'b1; w_addr = 6'd2; data_in = 13'h0AAA;
      tick();
      w_rb = 1'b0;
      chk("t4_drop", 32'(wr_drop0), 32'd1);
      tick();
      chk("t4_drop_pulse", 32'(wr_drop0), 32'd0);
      wait_idle();
      ra_addr = 6'd2;
      #1;
      chk("t4_entry", 32'(ra0), 32'h0000);

      // out-of-range write on DEPTH=48, in range on DEPTH=64
      w_rb = 1'b1; w_addr = 6'd50; data_in = 13'h0555; ra_addr = 6'd50;
      tick();
      w_rb = 1'b0;
      chk("t5_drop48", 32'(wr_drop1), 32'd1);
      chk("t5_ra48", 32'(ra1), 32'h0000);
      chk("t5_nodrop64", 32'(wr_drop0), 32'd0);
      chk("t5_ra64", 32'(ra0), 32'h0555);
      w_rb = 1'b1; w_addr = 6'd47; data_in = 13'h0777; ra_addr = 6'd47;
      tick();
      w_rb = 1'b0;
      chk("t5_last_nodrop", 32'(wr_drop1), 32'd0);
      chk("t5_last_bypass", 32'(ra1), 32'h0777);
      tick();
      chk("t5_last_mem", 32'(ra1), 32'h0777);

      // run-time clear, mid-sweep reset, ignored clr during sweep
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", 32'(busy2), 32'd1);
      n = 0;
      while (busy2 && n < 200) begin
         clr = (n == 30);
         tick();
         n++;
      end
      clr = 1'b0;
      chk("t6_busy_len", 32'(n), 32'd64);
      wait_idle();
      for (int i = 0; i < 64; i++) begin
         ra_addr = 6'(i);
         rb_addr = 6'(63 - i);
         #1;
         chk("t6_ra", 32'(ra2), 32'h1FFF);
         chk("t6_rb", 32'(rb2), 32'h1FFF);
      end

      // clear wins over a same-cycle write
      clr = 1'b1; w_rb = 1'b1; w_addr = 6'd7; data_in = 13'h0BBB;
      tick();
      clr = 1'b0; w_rb = 1'b0;
      chk("t7_drop", 32'(wr_drop0), 32'd1);
      chk("t7_busy", 32'(busy0), 32'd1);
      wait_idle();
      ra_addr = 6'd7; rb_addr = 6'd7;
      #1;
      chk("t7_entry", 32'(ra0), 32'h0000);
      chk("t7_entry_init", 32'(ra2), 32'h1FFF);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
